// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: sweep FSM states and
// default geometry constants reused by processor-level defines.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Zeroing sweep sequencer: walks entries 1..NUM_REGS-1 after reset or a clear
// request and flags the array busy until the walk is done.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    output logic          busy_o,
    output logic          zero_we_o,
    output logic [AW-1:0] zero_addr_o
);

    localparam logic [AW-1:0] LAST_PTR  = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] FIRST_PTR = AW'(1);

    state_e        state_r;
    state_e        next_state_s;
    logic [AW-1:0] clr_ptr_r;
    logic [AW-1:0] next_ptr_s;

    // Next-state and pointer logic; a clear request always restarts at entry 1.
    always_comb begin
        next_state_s = state_r;
        next_ptr_s   = clr_ptr_r;
        case (state_r)
            CLEAR: begin
                if (clr_i) begin
                    next_ptr_s = FIRST_PTR;
                end else if (clr_ptr_r == LAST_PTR) begin
                    next_state_s = READY;
                    next_ptr_s   = FIRST_PTR;
                end else begin
                    next_ptr_s = clr_ptr_r + AW'(1);
                end
            end
            READY: begin
                if (clr_i) begin
                    next_state_s = CLEAR;
                    next_ptr_s   = FIRST_PTR;
                end else begin
                    next_ptr_s = clr_ptr_r;
                end
            end
            default: begin
                next_state_s = CLEAR;
                next_ptr_s   = FIRST_PTR;
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= CLEAR;
            clr_ptr_r <= FIRST_PTR;
        end else begin
            state_r   <= next_state_s;
            clr_ptr_r <= next_ptr_s;
        end
    end

    assign busy_o      = (state_r == CLEAR);
    assign zero_we_o   = (state_r == CLEAR);
    assign zero_addr_o = clr_ptr_r;

endmodule

// File: rtl/regfile_mp.sv
// Two-write, multi-read register file with hardwired-zero entry 0, optional
// write-to-read forwarding, a sticky write-collision flag and a sweep clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int DBG_IDX    = 3,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         clr_i,
    input  logic                         wa_we_i,
    input  logic [AW-1:0]                wa_addr_i,
    input  logic [DATA_WIDTH-1:0]        wa_data_i,
    input  logic                         wb_we_i,
    input  logic [AW-1:0]                wb_addr_i,
    input  logic [DATA_WIDTH-1:0]        wb_data_i,
    input  logic [NUM_RD*AW-1:0]         rd_addr_i,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
    output logic                         busy_o,
    output logic                         coll_o,
    output logic [DATA_WIDTH-1:0]        dbg_o
);

    logic [DATA_WIDTH-1:0] mem_r [1:NUM_REGS-1];
    logic                  busy_s;
    logic                  zero_we_s;
    logic [AW-1:0]         zero_addr_s;
    logic                  coll_r;
    logic                  wa_ok_s;
    logic                  wb_ok_s;
    logic                  coll_hit_s;

    regfile_clr_seq #(
        .NUM_REGS (NUM_REGS)
    ) u_clr_seq (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (clr_i),
        .busy_o      (busy_s),
        .zero_we_o   (zero_we_s),
        .zero_addr_o (zero_addr_s)
    );

    // A clear request in READY discards any write issued alongside it.
    assign wa_ok_s    = !busy_s && !clr_i && wa_we_i && (wa_addr_i != '0);
    assign wb_ok_s    = !busy_s && !clr_i && wb_we_i && (wb_addr_i != '0);
    assign coll_hit_s = wa_ok_s && wb_ok_s && (wa_addr_i == wb_addr_i);

    // Storage update; no reset here, the sweep is the only way it gets zeroed.
    always_ff @(posedge clk_i) begin
        if (zero_we_s) begin
            mem_r[zero_addr_s] <= '0;
        end else begin
            if (wb_ok_s) begin
                mem_r[wb_addr_i] <= wb_data_i;
            end
            if (wa_ok_s) begin
                mem_r[wa_addr_i] <= wa_data_i;
            end
        end
    end

    // Sticky collision flag; a clear request takes precedence over a new hit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            coll_r <= 1'b0;
        end else if (clr_i) begin
            coll_r <= 1'b0;
        end else if (coll_hit_s) begin
            coll_r <= 1'b1;
        end else begin
            coll_r <= coll_r;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [AW-1:0]         ra_s;
            logic [DATA_WIDTH-1:0] rd_lane_s;

            assign ra_s = rd_addr_i[k*AW +: AW];

            // Read lane with port A winning over port B when forwarding.
            always_comb begin
                rd_lane_s = '0;
                if (busy_s || (ra_s == '0)) begin
                    rd_lane_s = '0;
                end else if ((BYPASS != 0) && wa_we_i && (wa_addr_i == ra_s)) begin
                    rd_lane_s = wa_data_i;
                end else if ((BYPASS != 0) && wb_we_i && (wb_addr_i == ra_s)) begin
                    rd_lane_s = wb_data_i;
                end else begin
                    rd_lane_s = mem_r[ra_s];
                end
            end

            assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = rd_lane_s;
        end

        if ((DBG_IDX <= 0) || (DBG_IDX >= NUM_REGS)) begin : g_dbg_zero
            assign dbg_o = '0;
        end else begin : g_dbg
            logic [DATA_WIDTH-1:0] dbg_s;

            // Debug mirror of one entry, never forwarded.
            always_comb begin
                dbg_s = '0;
                if (busy_s) begin
                    dbg_s = '0;
                end else begin
                    dbg_s = mem_r[DBG_IDX];
                end
            end

            assign dbg_o = dbg_s;
        end
    endgenerate

    assign busy_o = busy_s;
    assign coll_o = coll_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic compared against a behavioural array model.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int DBG = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              wa_we;
    logic [AW-1:0]     wa_addr;
    logic [DW-1:0]     wa_data;
    logic              wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD*DW-1:0] rd_data_nb;
    logic              busy, busy_nb;
    logic              coll, coll_nb;
    logic [DW-1:0]     dbg, dbg_nb;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: array contents, remaining sweep cycles, sticky flag.
    logic [DW-1:0] m_mem [0:NR-1];
    int            m_sweep;
    bit            m_coll;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(1), .DBG_IDX(DBG)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
        .wa_we_i(wa_we), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .busy_o(busy), .coll_o(coll), .dbg_o(dbg)
    );

    regfile_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(0), .DBG_IDX(DBG)) dut_nb (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr),
        .wa_we_i(wa_we), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb),
        .busy_o(busy_nb), .coll_o(coll_nb), .dbg_o(dbg_nb)
    );

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (m_sweep > 0) return '0;
        if (a == '0) return '0;
        if (byp && wa_we && wa_addr == a) return wa_data;
        if (byp && wb_we && wb_addr == a) return wb_data;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        m_sweep = NR - 1;
        m_coll  = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (clr) begin
            m_sweep = NR - 1;
            m_coll  = 1'b0;
        end else if (m_sweep > 0) begin
            m_sweep--;
            if (m_sweep == 0) begin
                for (int i = 0; i < NR; i++) m_mem[i] = '0;
            end
        end else begin
            if (wa_we && wb_we && wa_addr == wb_addr && wa_addr != '0) m_coll = 1'b1;
            if (wb_we && wb_addr != '0) m_mem[wb_addr] = wb_data;
            if (wa_we && wa_addr != '0) m_mem[wa_addr] = wa_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        clr   = 1'b0;
        wa_we = 1'b0; wa_addr = '0; wa_data = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; idle(); set_rd(5'd1, 5'd3); model_reset();
        #13;
        n_total++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else n_pass++;
        n_total++; if (coll !== 1'b0) $display("FAIL rst_coll: got %b want 0", coll); else n_pass++;
        n_total++; if (rd_data !== '0) $display("FAIL rst_rd: got %h want 0", rd_data); else n_pass++;
        n_total++; if (dbg !== '0) $display("FAIL rst_dbg: got %h want 0", dbg); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; model_reset();
        #1;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        n_total++; if (n !== 31) $display("FAIL rst_busy_len: got %0d want 31", n); else n_pass++;
        for (int a = 0; a < NR; a++) begin
            set_rd(AW'(a), AW'(NR - 1 - a));
            #1;
            n_total++;
            if (rd_data !== '0) $display("FAIL sweep_zero: addr %0d got %h want 0", a, rd_data);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        idle();
        wa_we = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_0033;
        set_rd(5'd5, 5'd8);
        #1;
        n_total++; if (rd_data[DW-1:0] !== 32'hDEADBEEF) $display("FAIL byp_a: got %h want deadbeef", rd_data[DW-1:0]); else n_pass++;
        n_total++; if (rd_data[2*DW-1:DW] !== 32'h33) $display("FAIL byp_b: got %h want 33", rd_data[2*DW-1:DW]); else n_pass++;
        n_total++; if (rd_data_nb[DW-1:0] !== 32'h0) $display("FAIL nobyp_old: got %h want 0", rd_data_nb[DW-1:0]); else n_pass++;
        tick(); idle(); #1;
        n_total++; if (rd_data_nb[DW-1:0] !== 32'hDEADBEEF) $display("FAIL nobyp_new: got %h want deadbeef", rd_data_nb[DW-1:0]); else n_pass++;
        n_total++; if (rd_data[2*DW-1:DW] !== 32'h33) $display("FAIL stored_b: got %h want 33", rd_data[2*DW-1:DW]); else n_pass++;
    endtask

    task automatic test_collision();
        int n;
        idle();
        wa_we = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        set_rd(5'd7, 5'd0);
        #1;
        n_total++; if (rd_data[DW-1:0] !== 32'h11) $display("FAIL coll_byp: got %h want 11", rd_data[DW-1:0]); else n_pass++;
        tick(); idle(); #1;
        n_total++; if (rd_data[DW-1:0] !== 32'h11) $display("FAIL coll_data: got %h want 11", rd_data[DW-1:0]); else n_pass++;
        n_total++; if (coll !== 1'b1) $display("FAIL coll_set: got %b want 1", coll); else n_pass++;
        tick(); tick(); tick();
        n_total++; if (coll !== 1'b1) $display("FAIL coll_sticky: got %b want 1", coll); else n_pass++;
        clr = 1'b1; tick(); clr = 1'b0; #1;
        n_total++; if (coll !== 1'b0) $display("FAIL coll_clr: got %b want 0", coll); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL coll_busy: got %b want 1", busy); else n_pass++;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        n_total++; if (busy !== 1'b0) $display("FAIL coll_sweep_end: got %b want 0", busy); else n_pass++;
        n_total++; if (rd_data[DW-1:0] !== 32'h0) $display("FAIL coll_cleared: got %h want 0", rd_data[DW-1:0]); else n_pass++;
    endtask

    task automatic test_clear_discard();
        int n;
        idle();
        wa_we = 1'b1; wa_addr = 5'd9; wa_data = 32'hA5;
        tick(); idle(); set_rd(5'd9, 5'd10); #1;
        n_total++; if (rd_data[DW-1:0] !== 32'hA5) $display("FAIL cd_pre: got %h want a5", rd_data[DW-1:0]); else n_pass++;
        clr = 1'b1; wa_we = 1'b1; wa_addr = 5'd10; wa_data = 32'h77;
        tick(); idle(); #1;
        n_total++; if (busy !== 1'b1) $display("FAIL cd_busy: got %b want 1", busy); else n_pass++;
        n = 0;
        while (busy && n < 100) begin
            wa_we = 1'b1; wa_addr = 5'd9;  wa_data = $urandom;
            wb_we = 1'b1; wb_addr = 5'd10; wb_data = $urandom;
            #1;
            n_total++; if (rd_data !== '0) $display("FAIL cd_rd_busy: got %h want 0", rd_data); else n_pass++;
            n++; tick();
        end
        idle(); #1;
        n_total++; if (n !== 31) $display("FAIL cd_busy_len: got %0d want 31", n); else n_pass++;
        n_total++; if (rd_data[DW-1:0] !== 32'h0) $display("FAIL cd_addr9: got %h want 0", rd_data[DW-1:0]); else n_pass++;
        n_total++; if (rd_data[2*DW-1:DW] !== 32'h0) $display("FAIL cd_addr10: got %h want 0", rd_data[2*DW-1:DW]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        idle();
        wa_we = 1'b1; wa_addr = 5'd12; wb_we = 1'b1; wb_addr = 5'd12;
        wa_data = 32'h1; wb_data = 32'h2;
        tick(); idle();
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0; model_reset(); #1;
        n_total++; if (busy !== 1'b1) $display("FAIL rm_busy: got %b want 1", busy); else n_pass++;
        n_total++; if (rd_data !== '0) $display("FAIL rm_rd: got %h want 0", rd_data); else n_pass++;
        tick();
        rst_n = 1'b1; #1;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        n_total++; if (n !== 31) $display("FAIL rm_busy_len: got %0d want 31", n); else n_pass++;
        n_total++; if (coll !== 1'b0) $display("FAIL rm_coll: got %b want 0", coll); else n_pass++;
        wa_we = 1'b1; wa_addr = 5'd3; wa_data = 32'h1234;
        tick(); idle(); #1;
        n_total++; if (dbg !== 32'h1234) $display("FAIL rm_dbg: got %h want 1234", dbg); else n_pass++;
        wa_we = 1'b1; wa_addr = 5'd0; wa_data = 32'hFF; set_rd(5'd0, 5'd3); #1;
        n_total++; if (rd_data[DW-1:0] !== 32'h0) $display("FAIL rm_zero_byp: got %h want 0", rd_data[DW-1:0]); else n_pass++;
        tick(); idle(); #1;
        n_total++; if (rd_data[DW-1:0] !== 32'h0) $display("FAIL rm_zero: got %h want 0", rd_data[DW-1:0]); else n_pass++;
        n_total++; if (rd_data[2*DW-1:DW] !== 32'h1234) $display("FAIL rm_addr3: got %h want 1234", rd_data[2*DW-1:DW]); else n_pass++;
    endtask

    task automatic test_random();
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] e;
        for (int c = 0; c < 400; c++) begin
            clr     = ($urandom_range(0, 59) == 0);
            wa_we   = $urandom_range(0, 1);
            wb_we   = $urandom_range(0, 1);
            wa_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
            wb_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
            wa_data = $urandom;
            wb_data = $urandom;
            a0 = AW'($urandom_range(0, NR - 1));
            a1 = $urandom_range(0, 1) ? wb_addr : AW'($urandom_range(0, 7));
            set_rd(a0, a1);
            #1;
            e = exp_rd(a0, 1'b1);
            n_total++; if (rd_data[DW-1:0] !== e) $display("FAIL rnd_rd0: cyc %0d got %h want %h", c, rd_data[DW-1:0], e); else n_pass++;
            e = exp_rd(a1, 1'b1);
            n_total++; if (rd_data[2*DW-1:DW] !== e) $display("FAIL rnd_rd1: cyc %0d got %h want %h", c, rd_data[2*DW-1:DW], e); else n_pass++;
            e = exp_rd(a0, 1'b0);
            n_total++; if (rd_data_nb[DW-1:0] !== e) $display("FAIL rnd_nb0: cyc %0d got %h want %h", c, rd_data_nb[DW-1:0], e); else n_pass++;
            e = (m_sweep > 0) ? '0 : m_mem[DBG];
            n_total++; if (dbg !== e || dbg_nb !== e) $display("FAIL rnd_dbg: cyc %0d got %h/%h want %h", c, dbg, dbg_nb, e); else n_pass++;
            n_total++; if (busy !== (m_sweep > 0) || busy_nb !== (m_sweep > 0)) $display("FAIL rnd_busy: cyc %0d got %b/%b want %b", c, busy, busy_nb, m_sweep > 0); else n_pass++;
            n_total++; if (coll !== m_coll || coll_nb !== m_coll) $display("FAIL rnd_coll: cyc %0d got %b/%b want %b", c, coll, coll_nb, m_coll); else n_pass++;
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_mem[i] = '0;
        test_reset();
        test_bypass();
        test_collision();
        test_clear_discard();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL expose these parameters:
- DATA_WIDTH, 32, width of each register.
- NUM_REGS, 32, number of entries, power of two, 4 to 64; entry 0 is hardwired zero.
- NUM_RD, 2, number of read ports, 1 to 4.
- BYPASS, 1, 1 enables write-to-read forwarding in the same cycle.
- DBG_IDX, 3, entry mirrored on dbg_o.

REQ-002 AW SHALL be a localparam equal to $clog2(NUM_REGS).

REQ-003 The module SHALL have these ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- clr_i  in  1  soft-clear request; starts a zeroing sweep.
- wa_we_i  in  1  write port A enable.
- wa_addr_i  in  AW  write port A address.
- wa_data_i  in  DATA_WIDTH  write port A data.
- wb_we_i  in  1  write port B enable.
- wb_addr_i  in  AW  write port B address.
- wb_data_i  in  DATA_WIDTH  write port B data.
- rd_addr_i  in  NUM_RD*AW  packed read addresses; port k occupies slice k.
- rd_data_o  out  NUM_RD*DATA_WIDTH  packed read data.
- busy_o  out  1  high while a zeroing sweep is in progress.
- coll_o  out  1  sticky flag: both write ports targeted the same nonzero address.
- dbg_o  out  DATA_WIDTH  contents of entry DBG_IDX.

Function
REQ-004 The module SHALL implement a two-state FSM, CLEAR and READY, and SHALL hold a clear pointer clr_ptr of AW bits.

REQ-005 In CLEAR, each cycle SHALL write zero to entry clr_ptr and increment clr_ptr.
- When clr_ptr equals NUM_REGS-1, that entry SHALL be written and the next state SHALL be READY.
- A full sweep therefore takes NUM_REGS-1 cycles.

REQ-006 busy_o SHALL equal (state == CLEAR) and SHALL be driven directly from state.

REQ-007 In READY, clr_i=1 SHALL move the FSM to CLEAR with clr_ptr=1 on the next edge.
- Any write requested in that same cycle SHALL be discarded.

REQ-008 clr_i=1 while already in CLEAR SHALL restart the sweep with clr_ptr=1.

REQ-009 In CLEAR, wa_we_i and wb_we_i SHALL be ignored.
- All rd_data_o lanes and dbg_o SHALL read zero.

REQ-010 In READY, an enabled write SHALL update its entry on the rising edge.
- Writes to address 0 SHALL be ignored.

REQ-011 When both ports write the same nonzero address in the same cycle, port A's data SHALL be stored.
- coll_o SHALL be set on that edge.

REQ-012 coll_o SHALL clear only on reset or on an edge where clr_i=1.
- If clr_i and a collision occur in the same cycle, clr_i SHALL win and coll_o SHALL clear.

REQ-013 Each read port SHALL be combinational.
- Address 0 SHALL return 0.
- If BYPASS=1 and the FSM is in READY, a read address matching an enabled write address SHALL return that write's data, with port A taking priority over port B.
- Otherwise the port SHALL return the stored entry.

REQ-014 dbg_o SHALL be combinational from entry DBG_IDX, with no bypass.
- DBG_IDX=0 SHALL yield 0.

REQ-015 The storage array SHALL be NUM_REGS-1 entries, indices 1 to NUM_REGS-1.
- Its contents SHALL be defined only after the first sweep completes.

Reset
REQ-016 While rst_n_i=0, regardless of clk_i:
- state SHALL be CLEAR.
- clr_ptr SHALL be 1.
- coll_o SHALL be 0.
- busy_o SHALL be 1.
- rd_data_o and dbg_o SHALL be 0.

REQ-017 Reset asserted mid-sweep or mid-write SHALL abort the operation.
- After release, a full sweep SHALL restart from entry 1.

REQ-018 The storage array itself SHALL NOT be reset asynchronously; it SHALL be zeroed only by the sweep.

Structure
REQ-019 A shared package, regfile_pkg, SHALL hold:
- the FSM state enum (CLEAR, READY);
- the default DATA_WIDTH and NUM_REGS constants, shared with proc_define usage.

REQ-020 The sweep FSM, clr_ptr, and busy generation SHALL be one sub-module, regfile_clr_seq.
- It SHALL output a zeroing write-enable and address.
- The storage, ports, and collision logic SHALL remain in regfile_mp.

Verification
REQ-021 Reset release with NUM_REGS=32: busy_o=1 for exactly 31 cycles, then 0. After that, reading every address returns 0.

REQ-022 In READY, write A addr 5 = 0xDEADBEEF while read port 0 reads addr 5 in the same cycle:
- With BYPASS=1, 0xDEADBEEF appears that cycle.
- With BYPASS=0, the old value (0) appears that cycle and 0xDEADBEEF the next.

REQ-023 Same cycle: A writes addr 7 = 0x11 and B writes addr 7 = 0x22. Required: entry 7 reads 0x11 and coll_o rises and stays 1. A later clr_i pulse drops coll_o.

REQ-024 In READY, write addr 9 = 0xA5. Assert clr_i together with an A write to addr 10 = 0x77. Required:
- busy_o rises next cycle;
- writes issued during busy are ignored;
- after the sweep, addr 9 and addr 10 both read 0.

REQ-025 At sweep cycle 10, assert rst_n_i=0 for 1 cycle. Required: busy_o stays 1 for a full 31 cycles after release. Write addr 3 = 0x1234 and check dbg_o=0x1234 (DBG_IDX=3). Write addr 0 = 0xFF and check rd_addr 0 returns 0.
